// File: rtl/mmac_pkg.sv
// mmac_pkg: shared widths, matrix type and job-sequencer state encoding for the 4x4 MAC.
package mmac_pkg;
    localparam int DATA_WIDTH = 16;
    localparam int CNT_WIDTH  = 8;
    localparam int JOBS_WIDTH = 16;
    typedef logic [0:3][0:3][DATA_WIDTH-1:0] mat4_t;
    typedef enum logic [1:0] {IDLE, CLEAR, ACCUM, OUT} seq_state_t;
endpackage

// File: rtl/mmac_job_sequencer.sv
// mmac_job_sequencer: runs one accumulation job per command through the 4x4 MAC and hands back the result.
module mmac_job_sequencer #(
    parameter int DATA_WIDTH = mmac_pkg::DATA_WIDTH,
    parameter int CNT_WIDTH  = mmac_pkg::CNT_WIDTH,
    parameter int JOBS_WIDTH = mmac_pkg::JOBS_WIDTH
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 cmd_valid,
    output logic                                 cmd_ready,
    input  logic [CNT_WIDTH-1:0]                 cmd_len,
    input  logic                                 op_valid,
    output logic                                 op_ready,
    input  logic [0:3][0:3][DATA_WIDTH-1:0]      op_matrix_1,
    input  logic [0:3][0:3][DATA_WIDTH-1:0]      op_matrix_2,
    output logic                                 mac_enable,
    output logic                                 mac_clear,
    output logic [0:3][0:3][DATA_WIDTH-1:0]      mac_matrix_1,
    output logic [0:3][0:3][DATA_WIDTH-1:0]      mac_matrix_2,
    input  logic [0:3][0:3][DATA_WIDTH-1:0]      mac_result,
    output logic                                 res_valid,
    input  logic                                 res_ready,
    output logic [0:3][0:3][DATA_WIDTH-1:0]      res_matrix,
    output logic                                 busy,
    output logic [JOBS_WIDTH-1:0]                jobs_done
);
    import mmac_pkg::*;

    seq_state_t           state;
    logic [CNT_WIDTH-1:0] remaining;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            remaining <= '0;
            jobs_done <= '0;
            cmd_ready <= 1'b1;
            op_ready  <= 1'b0;
            mac_clear <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cmd_valid && cmd_ready) begin
                    remaining <= cmd_len;
                    state     <= CLEAR;
                    cmd_ready <= 1'b0;
                    mac_clear <= 1'b1;
                end
                CLEAR: begin
                    mac_clear <= 1'b0;
                    // a zero-length job skips straight to presenting the freshly cleared accumulator
                    if (remaining != '0) begin
                        state    <= ACCUM;
                        op_ready <= 1'b1;
                    end else begin
                        state     <= OUT;
                        res_valid <= 1'b1;
                    end
                end
                ACCUM: if (op_valid) begin
                    remaining <= remaining - CNT_WIDTH'(1);
                    if (remaining == CNT_WIDTH'(1)) begin
                        state     <= OUT;
                        op_ready  <= 1'b0;
                        res_valid <= 1'b1;
                    end
                end
                OUT: if (res_ready) begin
                    state     <= IDLE;
                    res_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    jobs_done <= jobs_done + JOBS_WIDTH'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    // op_ready is high exactly in ACCUM, so it gates the operand path
    assign mac_enable   = op_ready & op_valid;
    assign mac_matrix_1 = op_ready ? op_matrix_1 : '0;
    assign mac_matrix_2 = op_ready ? op_matrix_2 : '0;
    assign res_matrix   = mac_result;
    assign busy         = state != IDLE;
endmodule

// File: tb/tb_mmac_job_sequencer.sv
// tb_mmac_job_sequencer: scoreboard bench with a behavioural MAC stand-in and a job-level reference model.
module tb_mmac_job_sequencer;
    import mmac_pkg::*;

    logic                  clock = 0, reset = 1;
    logic                  cmd_valid = 0, cmd_ready;
    logic [CNT_WIDTH-1:0]  cmd_len = '0;
    logic                  op_valid = 0, op_ready;
    mat4_t                 op_matrix_1 = '0, op_matrix_2 = '0;
    logic                  mac_enable, mac_clear;
    mat4_t                 mac_matrix_1, mac_matrix_2, mac_result, res_matrix;
    logic                  res_valid, res_ready = 0, busy;
    logic [JOBS_WIDTH-1:0] jobs_done;

    int    checks = 0, failures = 0, cyc = 0, exp_jobs = 0;
    bit    in_accum = 0;
    mat4_t exp_q[$];
    mat4_t acc = '0;

    mmac_job_sequencer dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_matrix_1(op_matrix_1), .op_matrix_2(op_matrix_2),
        .mac_enable(mac_enable), .mac_clear(mac_clear),
        .mac_matrix_1(mac_matrix_1), .mac_matrix_2(mac_matrix_2), .mac_result(mac_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_matrix(res_matrix),
        .busy(busy), .jobs_done(jobs_done)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic mat4_t mat_mac(input mat4_t s, input mat4_t a, input mat4_t b);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                for (int k = 0; k < 4; k++)
                    s[i][j] = s[i][j] + a[i][k] * b[k][j];
        return s;
    endfunction

    function automatic mat4_t gen(input int kind, input bit right);
        mat4_t m;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                case (kind)
                    1:       m[i][j] = right ? 16'd3 : 16'd2;
                    2:       m[i][j] = (i == j) ? 16'd1 : 16'd0;
                    3:       m[i][j] = 16'd1;
                    default: m[i][j] = 16'($urandom);
                endcase
        return m;
    endfunction

    // stand-in for the neighbouring MAC unit
    always @(posedge clock)
        if (mac_clear) acc <= '0;
        else if (mac_enable) acc <= mat_mac(acc, mac_matrix_1, mac_matrix_2);
    assign mac_result = acc;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic timeout(input string name);
        failures++;
        $display("FAIL timeout waiting for %s", name);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    endtask

    always @(negedge clock) if (!reset) begin
        chk("op_ready", op_ready, in_accum);
        chk("mac_enable", mac_enable, in_accum && op_valid);
        chk("mac_matrix_1", mac_matrix_1, in_accum ? op_matrix_1 : '0);
        chk("mac_matrix_2", mac_matrix_2, in_accum ? op_matrix_2 : '0);
        chk("clear_and_enable", mac_clear && mac_enable, 1'b0);
        if (in_accum) chk("res_valid_in_accum", res_valid, 1'b0);
        if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_result: got %h want none", res_matrix);
            end else chk("result", res_matrix, exp_q.pop_front());
            chk("jobs_done_at_accept", jobs_done, exp_jobs);
            exp_jobs++;
        end
    end

    // stall < 0 means random 0..-stall idle cycles between pairs; abort > 0 resets after that many pairs
    task automatic run_job(input int len, input int kind, input int stall, input int bp, input int abort = 0);
        mat4_t a[$], b[$];
        mat4_t want = '0;
        int t, n, s;
        bit stalled = 0;
        for (int i = 0; i < len; i++) begin
            a.push_back(gen(kind, 0));
            b.push_back(gen(kind, 1));
            want = mat_mac(want, a[i], b[i]);
        end
        exp_q.push_back(want);
        res_ready = (bp == 0);
        cmd_len = CNT_WIDTH'(len);
        cmd_valid = 1;
        n = 0;
        forever begin @(negedge clock); if (cmd_ready) break; if (++n > 200) timeout("cmd_ready"); end
        t = cyc;
        @(posedge clock); #1 cmd_valid = 0;
        @(negedge clock);
        chk("clear_pulse", {mac_clear, mac_enable, busy}, 3'b101);
        @(posedge clock); #1;
        in_accum = (len != 0);
        for (int i = 0; i < len; i++) begin
            s = (i == 0) ? 0 : (stall < 0 ? int'($urandom_range(0, -stall)) : stall);
            if (s != 0) stalled = 1;
            repeat (s) begin @(posedge clock); #1; end
            op_matrix_1 = a[i]; op_matrix_2 = b[i]; op_valid = 1;
            n = 0;
            forever begin @(negedge clock); if (op_ready) break; if (++n > 200) timeout("op_ready"); end
            @(posedge clock); #1;
            op_valid = 0; op_matrix_1 = gen(0, 0); op_matrix_2 = gen(0, 1);
            if (i == len - 1) in_accum = 0;
            if (abort != 0 && i == abort - 1) begin
                in_accum = 0; reset = 1; res_ready = 0;
                void'(exp_q.pop_back());
                @(posedge clock); #1 reset = 0; exp_jobs = 0;
                @(negedge clock);
                chk("after_reset", {op_ready, busy, cmd_ready, res_valid}, 4'b0010);
                chk("after_reset_jobs", jobs_done, 0);
                @(posedge clock); #1;
                return;
            end
        end
        n = 0;
        forever begin @(negedge clock); if (res_valid) break; if (++n > 400) timeout("res_valid"); end
        if (!stalled) chk("latency", cyc - t, len + 2);
        if (bp > 0) begin
            repeat (bp) begin
                @(posedge clock); #1;
                @(negedge clock);
                chk("res_hold_valid", res_valid, 1'b1);
                chk("res_hold_matrix", res_matrix, want);
            end
            @(posedge clock); #1 res_ready = 1;
            @(negedge clock);
        end
        @(posedge clock); #1 res_ready = 0;
        @(negedge clock);
        chk("idle_after_accept", {cmd_ready, busy, res_valid}, 3'b100);
        chk("jobs_done", jobs_done, exp_jobs);
        @(posedge clock); #1;
    endtask

    initial begin
        #2000000;
        timeout("global watchdog");
    end

    initial begin
        @(posedge clock); #1;
        @(negedge clock);
        chk("reset_outputs", {op_ready, mac_clear, res_valid, busy}, 4'b0000);
        @(posedge clock); #1 reset = 0;
        @(negedge clock);
        chk("reset_idle", {cmd_ready, busy, res_valid, mac_enable}, 4'b1000);
        chk("reset_jobs", jobs_done, 0);
        @(posedge clock); #1;
        run_job(1, 1, 0, 0);
        run_job(3, 2, 2, 0);
        run_job(0, 0, 0, 5);
        run_job(2, 3, 0, 0);
        run_job(1, 3, 0, 0);
        run_job(4, 3, 0, 0, 1);
        run_job(1, 3, 0, 0);
        run_job(255, 0, 0, 1);
        for (int j = 0; j < 30; j++)
            run_job(int'($urandom_range(0, 6)), 0, -2, int'($urandom_range(0, 3)));
        chk("final_jobs_done", jobs_done, exp_jobs);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
